// File: rtl/bu_operand_router.sv
// -----------------------------------------------------------------------------
// bu_operand_router
//   Pipelined operand router for the NUM_BU butterfly array (NTT and iNTT).
//   Each accepted beat carries 2*NUM_BU coefficients from the bank read side.
//   They are paired per the current stage length into A/B operands, and each
//   butterfly gets its zeta ROM index. The router counts beats within a stage
//   and pulses stage_done when the last beat of the stage is accepted.
//
//   Optional build macro: BU_ROUTER_STALL_CNT_EN adds a 16-bit saturating
//   stall counter output (stall_cnt).
//
// Ports
//   clk_i, rst_i        clock, synchronous active-low reset
//   start_i             stage start pulse; latches len_i and is_ntt_i
//   len_i               butterfly distance for the stage (power of 2, 2..N/2)
//   is_ntt_i            1 = NTT, 0 = iNTT
//   in_valid/in_ready   input beat handshake
//   in_data             2*NUM_BU lanes of CW bits, lane j at [j*CW +: CW]
//   out_valid/out_ready operand beat handshake
//   a_data, b_data      top/bottom operand for BU i at [i*CW +: CW]
//   zeta_idx            zeta ROM index for BU i at [i*ZIDX_W +: ZIDX_W]
//   out_ntt             mode tag travelling with the beat
//   stage_done          one-cycle pulse after the last beat of a stage is taken
//   cfg_err             latched illegal-length flag
//   stall_cnt           (macro only) cycles with out_valid && !out_ready
// -----------------------------------------------------------------------------
module bu_operand_router #(
   parameter int DATA_WIDTH = 13,
   parameter int NUM_BU     = 8,
   parameter int N_COEFF    = 256,
   parameter int ZIDX_W     = 7
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   start_i,
   input  logic [$clog2(N_COEFF)-1:0]             len_i,
   input  logic                                   is_ntt_i,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [2*NUM_BU*(DATA_WIDTH-1)-1:0]     in_data,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [NUM_BU*(DATA_WIDTH-1)-1:0]       a_data,
   output logic [NUM_BU*(DATA_WIDTH-1)-1:0]       b_data,
   output logic [NUM_BU*ZIDX_W-1:0]               zeta_idx,
   output logic                                   out_ntt,
   output logic                                   stage_done,
   output logic                                   cfg_err
`ifdef BU_ROUTER_STALL_CNT_EN
   ,
   output logic [15:0]                            stall_cnt
`endif
);

   localparam int CW     = DATA_WIDTH - 1;
   localparam int LEN_W  = $clog2(N_COEFF);
   localparam int LOG_N  = LEN_W;
   localparam int LOG_BU = $clog2(NUM_BU);
   localparam int BEATS  = N_COEFF / (2 * NUM_BU);
   localparam int BEAT_W = $clog2(BEATS);
   localparam int LOG_W  = $clog2(LEN_W) + 1;

   typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

   state_t state, state_nxt;

   logic [LOG_W-1:0]           len_log_q;
   logic                       ntt_q;
   logic [BEAT_W-1:0]          beat_q;
   logic                       hs;
   logic                       last_beat;
   logic                       start_legal;

   logic [NUM_BU*CW-1:0]       a_nxt, b_nxt;
   logic [NUM_BU*ZIDX_W-1:0]   zeta_nxt;

   logic [NUM_BU*CW-1:0]       a_p1, b_p1;
   logic [NUM_BU*ZIDX_W-1:0]   zeta_p1;
   logic                       ntt_p1;
   logic                       vld_p1;
   logic                       done_p1;
   logic                       err_q;

   function automatic logic len_legal(input logic [LEN_W-1:0] l);
      return (l >= LEN_W'(2)) && (l <= LEN_W'(N_COEFF / 2)) &&
             ((l & (l - LEN_W'(1))) == '0);
   endfunction

   function automatic logic [LOG_W-1:0] log2_len(input logic [LEN_W-1:0] l);
      logic [LOG_W-1:0] r;
      r = '0;
      for (int k = 0; k < LEN_W; k++) begin
         if (l[k]) r = LOG_W'(k);
      end
      return r;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign start_legal = len_legal(len_i);
   // Start cycles and reset cycles never accept data.
   assign in_ready    = rst_i && (state == RUN) && !start_i && (!vld_p1 || out_ready);
   assign hs          = in_valid && in_ready;
   assign last_beat   = (beat_q == BEAT_W'(BEATS - 1));

   // ---- stage p0: lane pairing and zeta index from the latched stage config
   always_comb begin
      int ll, s_log, s, t, p, g, z;
      a_nxt    = '0;
      b_nxt    = '0;
      zeta_nxt = '0;
      t = 0;
      p = 0;
      g = 0;
      z = 0;
      ll    = int'(len_log_q);
      s_log = (ll < LOG_BU) ? ll : LOG_BU;
      s     = 1 << s_log;
      for (int i = 0; i < NUM_BU; i++) begin
         // Groups of s butterflies each consume 2s consecutive lanes.
         t = ((i >> s_log) << (s_log + 1)) + (i & (s - 1));
         a_nxt[i*CW +: CW] = in_data[t*CW +: CW];
         b_nxt[i*CW +: CW] = in_data[(t+s)*CW +: CW];
         // Long strides: lanes are pre-arranged, so BU i maps to beat*NUM_BU+i.
         if (ll <= LOG_BU) p = int'(beat_q) * 2 * NUM_BU + t;
         else              p = int'(beat_q) * NUM_BU + i;
         g = p >> (ll + 1);
         z = ntt_q ? (1 << (LOG_N - ll - 1)) + g
                   : (1 << (LOG_N - ll)) - 1 - g;
         zeta_nxt[i*ZIDX_W +: ZIDX_W] = ZIDX_W'(z);
      end
   end

   always_comb begin
      state_nxt = state;
      if (start_i)                                 state_nxt = start_legal ? RUN : ERR;
      else if (state == RUN && hs && last_beat)    state_nxt = IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= state_nxt;
   end

   // ---- stage p1: output register, beat counter and stage bookkeeping
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         len_log_q <= '0;
         ntt_q     <= 1'b0;
         beat_q    <= '0;
         a_p1      <= '0;
         b_p1      <= '0;
         zeta_p1   <= '0;
         ntt_p1    <= 1'b0;
         vld_p1    <= 1'b0;
         done_p1   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_p1 <= 1'b0;
         if (start_i) begin
            // A start aborts any pending beat without signalling completion.
            vld_p1 <= 1'b0;
            beat_q <= '0;
            if (start_legal) begin
               len_log_q <= log2_len(len_i);
               ntt_q     <= is_ntt_i;
               err_q     <= 1'b0;
            end else begin
               err_q     <= 1'b1;
            end
         end else if (hs) begin
            a_p1    <= a_nxt;
            b_p1    <= b_nxt;
            zeta_p1 <= zeta_nxt;
            ntt_p1  <= ntt_q;
            vld_p1  <= 1'b1;
            if (last_beat) begin
               beat_q  <= '0;
               done_p1 <= 1'b1;
            end else begin
               beat_q  <= beat_q + BEAT_W'(1);
            end
         end else if (out_ready) begin
            vld_p1 <= 1'b0;
         end
      end
   end

`ifdef BU_ROUTER_STALL_CNT_EN
   logic [15:0] stall_q;
   always_ff @(posedge clk_i) begin
      if (!rst_i || start_i)          stall_q <= '0;
      else if (vld_p1 && !out_ready)  stall_q <= sat_inc16(stall_q);
   end
   assign stall_cnt = stall_q;
`endif

   assign a_data     = a_p1;
   assign b_data     = b_p1;
   assign zeta_idx   = zeta_p1;
   assign out_ntt    = ntt_p1;
   assign out_valid  = vld_p1;
   assign stage_done = done_p1;
   assign cfg_err    = err_q;

endmodule

// File: tb/tb_bu_operand_router.sv
// -----------------------------------------------------------------------------
// tb_bu_operand_router
//   Directed sequence with randomized coefficients and back-pressure, checked
//   against a behavioural reference of the pairing and zeta rules plus a queue
//   of expected output beats.
// -----------------------------------------------------------------------------
module tb_bu_operand_router;

   localparam int NB    = 8;
   localparam int NC    = 256;
   localparam int ZW    = 7;
   localparam int CW    = 12;
   localparam int BEATS = NC / (2 * NB);

   logic              clk = 1'b0;
   logic              rst_i = 1'b0;
   logic              start_i = 1'b0;
   logic [7:0]        len_i = '0;
   logic              is_ntt_i = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [2*NB*CW-1:0] in_data = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [NB*CW-1:0]  a_data, b_data;
   logic [NB*ZW-1:0]  zeta_idx;
   logic              out_ntt, stage_done, cfg_err;
`ifdef BU_ROUTER_STALL_CNT_EN
   logic [15:0]       stall_cnt;
`endif

   always #5 clk = ~clk;

   bu_operand_router dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
      .is_ntt_i(is_ntt_i), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .a_data(a_data), .b_data(b_data), .zeta_idx(zeta_idx), .out_ntt(out_ntt),
      .stage_done(stage_done), .cfg_err(cfg_err)
`ifdef BU_ROUTER_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   typedef struct packed {
      logic [NB*CW-1:0] a;
      logic [NB*CW-1:0] b;
      logic [NB*ZW-1:0] z;
      logic             n;
   } beat_t;

   int tests = 0;
   int fails = 0;

   logic [NB*CW-1:0] first_a, first_b;
   logic [NB*ZW-1:0] first_z, second_z;
   logic             first_n;
   int               pulses;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: butterflies in groups of s = min(len, NB) over 2s lanes.
   function automatic void model(input int len, input bit ntt, input int beat,
                                 input logic [2*NB*CW-1:0] din,
                                 output logic [NB*CW-1:0] ea, output logic [NB*CW-1:0] eb,
                                 output logic [NB*ZW-1:0] ez);
      int s, t, p, g, z;
      s = (len < NB) ? len : NB;
      ea = '0; eb = '0; ez = '0;
      for (int i = 0; i < NB; i++) begin
         t = (i / s) * 2 * s + (i % s);
         ea[i*CW +: CW] = din[t*CW +: CW];
         eb[i*CW +: CW] = din[(t+s)*CW +: CW];
         p = (len <= NB) ? beat * 2 * NB + t : beat * NB + i;
         g = p / (2 * len);
         z = ntt ? NC / (2 * len) + g : NC / len - 1 - g;
         ez[i*ZW +: ZW] = z[ZW-1:0];
      end
   endfunction

   function automatic logic [2*NB*CW-1:0] mk_data(input int beat, input bit rnd);
      logic [2*NB*CW-1:0] d;
      for (int j = 0; j < 2*NB; j++)
         d[j*CW +: CW] = rnd ? CW'($urandom) : CW'(j + 16 * beat);
      return d;
   endfunction

   task automatic run_stage(input int len, input bit ntt, input bit rnd, input bit stall);
      beat_t q[$];
      beat_t e;
      int    sent, popped, cyc;
      bit    exp_done, exp_rdy, hs, pop;
      sent = 0; popped = 0; cyc = 0; exp_done = 1'b0; pulses = 0;
      start_i = 1'b1; len_i = 8'(len); is_ntt_i = ntt; in_valid = 1'b1; out_ready = 1'b1;
      #1 check("start_in_ready", 128'(in_ready), 128'(0));
      tick();
      start_i = 1'b0;
      check("start_cfg_err", 128'(cfg_err), 128'(0));
      while ((sent < BEATS || q.size() != 0) && cyc < 400) begin
         check("out_valid", 128'(out_valid), 128'(q.size() != 0));
         check("stage_done", 128'(stage_done), 128'(exp_done));
         if (stage_done) pulses++;
         if (q.size() != 0) begin
            check("a_data", 128'(a_data), 128'(q[0].a));
            check("b_data", 128'(b_data), 128'(q[0].b));
            check("zeta_idx", 128'(zeta_idx), 128'(q[0].z));
            check("out_ntt", 128'(out_ntt), 128'(q[0].n));
            if (popped == 0) begin
               first_a = a_data; first_b = b_data; first_z = zeta_idx; first_n = out_ntt;
            end
            if (popped == 1) second_z = zeta_idx;
         end
         in_valid  = (sent < BEATS) && (!rnd || ($urandom % 4 != 0));
         in_data   = mk_data(sent, rnd);
         out_ready = stall ? ($urandom % 3 != 0) : 1'b1;
         #1;
         exp_rdy = (sent < BEATS) && (q.size() == 0 || out_ready);
         check("in_ready", 128'(in_ready), 128'(exp_rdy));
         hs  = in_valid && exp_rdy;
         pop = (q.size() != 0) && out_ready;
         if (hs) begin
            model(len, ntt, sent, in_data, e.a, e.b, e.z);
            e.n = ntt;
         end
         tick();
         if (pop) begin
            void'(q.pop_front());
            popped++;
         end
         exp_done = hs && (sent == BEATS - 1);
         if (hs) begin
            q.push_back(e);
            sent++;
         end
         cyc++;
      end
      tests++;
      assert (cyc < 400) else begin
         fails++;
         $error("FAIL stage_timeout observed=%0d expected=<400", cyc);
      end
      check("stage_done_tail", 128'(stage_done), 128'(exp_done));
      if (stage_done) pulses++;
      check("stage_done_pulses", 128'(pulses), 128'(1));
      in_valid = 1'b1;
      #1 check("idle_in_ready", 128'(in_ready), 128'(0));
      in_valid = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      logic [NB*CW-1:0] ea, eb, va, vb;
      logic [NB*ZW-1:0] ez, vz;
      int               rl;

      // Reset state
      rst_i = 1'b0;
      tick(); tick();
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_stage_done", 128'(stage_done), 128'(0));
      check("rst_cfg_err", 128'(cfg_err), 128'(0));
      check("rst_in_ready", 128'(in_ready), 128'(0));
      check("rst_a", 128'(a_data), 128'(0));
      check("rst_zeta", 128'(zeta_idx), 128'(0));
      rst_i = 1'b1;
      tick();

      // NTT len=128, counting lanes
      run_stage(128, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < NB; i++) begin
         va[i*CW +: CW] = CW'(i);
         vb[i*CW +: CW] = CW'(i + 8);
         vz[i*ZW +: ZW] = ZW'(1);
      end
      check("l128_a_beat0", 128'(first_a), 128'(va));
      check("l128_b_beat0", 128'(first_b), 128'(vb));
      check("l128_zeta_beat0", 128'(first_z), 128'(vz));

      // NTT len=2
      run_stage(2, 1'b1, 1'b0, 1'b0);
      check("l2_bu0_a", 128'(first_a[0 +: CW]), 128'(0));
      check("l2_bu0_b", 128'(first_b[0 +: CW]), 128'(2));
      check("l2_bu1_a", 128'(first_a[CW +: CW]), 128'(1));
      check("l2_bu1_b", 128'(first_b[CW +: CW]), 128'(3));
      check("l2_bu2_a", 128'(first_a[2*CW +: CW]), 128'(4));
      check("l2_bu2_b", 128'(first_b[2*CW +: CW]), 128'(6));
      check("l2_z_bu0", 128'(first_z[0 +: ZW]), 128'(64));
      check("l2_z_bu2", 128'(first_z[2*ZW +: ZW]), 128'(65));
      check("l2_z_bu7", 128'(first_z[7*ZW +: ZW]), 128'(67));
      check("l2_z_beat1_bu0", 128'(second_z[0 +: ZW]), 128'(68));

      // iNTT len=2, random data
      run_stage(2, 1'b0, 1'b1, 1'b0);
      check("intt_z_bu0", 128'(first_z[0 +: ZW]), 128'(127));
      check("intt_z_bu2", 128'(first_z[2*ZW +: ZW]), 128'(126));
      check("intt_out_ntt", 128'(first_n), 128'(0));

      // Random lengths, modes, data and back-pressure
      for (int r = 0; r < 6; r++) begin
         rl = 1 << (1 + ($urandom % 7));
         run_stage(rl, 1'($urandom), 1'b1, 1'b1);
      end

      // Output stall, then start while a beat is pending
      start_i = 1'b1; len_i = 8'd16; is_ntt_i = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      tick();
      start_i = 1'b0;
      in_valid = 1'b1; in_data = mk_data(0, 1'b1);
      #1 check("stall_first_in_ready", 128'(in_ready), 128'(1));
      model(16, 1'b1, 0, in_data, ea, eb, ez);
      tick();
      in_data = mk_data(1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("stall_out_valid", 128'(out_valid), 128'(1));
         check("stall_a", 128'(a_data), 128'(ea));
         check("stall_b", 128'(b_data), 128'(eb));
         check("stall_zeta", 128'(zeta_idx), 128'(ez));
         check("stall_in_ready", 128'(in_ready), 128'(0));
      end
`ifdef BU_ROUTER_STALL_CNT_EN
      check("stall_cnt", 128'(stall_cnt), 128'(3));
`endif
      start_i = 1'b1;
      #1 check("restart_in_ready", 128'(in_ready), 128'(0));
      tick();
      start_i = 1'b0; in_valid = 1'b0;
      check("restart_flush", 128'(out_valid), 128'(0));
      check("restart_no_done", 128'(stage_done), 128'(0));
`ifdef BU_ROUTER_STALL_CNT_EN
      check("stall_cnt_clear", 128'(stall_cnt), 128'(0));
`endif

      // Illegal length, then recovery
      out_ready = 1'b1;
      start_i = 1'b1; len_i = 8'd3; in_valid = 1'b1;
      tick();
      start_i = 1'b0;
      check("err_cfg_err", 128'(cfg_err), 128'(1));
      check("err_in_ready", 128'(in_ready), 128'(0));
      tick();
      check("err_hold", 128'(cfg_err), 128'(1));
      check("err_no_out", 128'(out_valid), 128'(0));
      start_i = 1'b1; len_i = 8'd16;
      tick();
      start_i = 1'b0; in_data = mk_data(0, 1'b1);
      check("recover_cfg_err", 128'(cfg_err), 128'(0));
      #1 check("recover_in_ready", 128'(in_ready), 128'(1));
      model(16, 1'b1, 0, in_data, ea, eb, ez);
      tick();
      in_valid = 1'b0;
      check("recover_out_valid", 128'(out_valid), 128'(1));
      check("recover_a", 128'(a_data), 128'(ea));
      check("recover_zeta", 128'(zeta_idx), 128'(ez));

      // Reset in the middle of a stage (during beat 3)
      start_i = 1'b1; len_i = 8'd64; is_ntt_i = 1'b1;
      tick();
      start_i = 1'b0; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_data = mk_data(k, 1'b1);
         tick();
      end
      rst_i = 1'b0; in_data = mk_data(3, 1'b1);
      tick();
      check("mrst_out_valid", 128'(out_valid), 128'(0));
      check("mrst_a", 128'(a_data), 128'(0));
      check("mrst_b", 128'(b_data), 128'(0));
      check("mrst_zeta", 128'(zeta_idx), 128'(0));
      check("mrst_out_ntt", 128'(out_ntt), 128'(0));
      check("mrst_stage_done", 128'(stage_done), 128'(0));
      check("mrst_in_ready", 128'(in_ready), 128'(0));
      rst_i = 1'b1; in_valid = 1'b0;
      tick();
      check("mrst_done_after", 128'(stage_done), 128'(0));
      run_stage(64, 1'b1, 1'b0, 1'b0);
      check("mrst_restart_a0", 128'(first_a[0 +: CW]), 128'(0));
      check("mrst_restart_z0", 128'(first_z[0 +: ZW]), 128'(2));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout observed=timeout expected=finish");
      $fatal(1, "simulation time limit");
   end

endmodule
